poly_ram_reader: RTL
====================

# poly_ram_reader

Reads one Kyber polynomial (256 × 12-bit coefficients) from the polynomial RAM, where it is stored as 32 words of 96 bits written by the small-polynomial generator. Streams the coefficients one per cycle to a downstream consumer over a valid/ready handshake, each tagged with its natural coefficient index. Sits on the read port of the polynomial RAM, feeding NTT, compress and encode stages.

## Interface

Parameters:
- RAM_RD_LAT, 1, RAM read latency in cycles. Only 1 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- active  in  1  start pulse, sampled only in IDLE.
- ram_r_start_offset  in  9  base RAM address of the polynomial, sampled with active.
- ren  out  1  RAM read enable.
- raddr  out  9  RAM read address, ram_r_start_offset + word, modulo 512.
- din  in  96  RAM read data, valid RAM_RD_LAT cycles after ren.
- coeff_out  out  12  coefficient value.
- coeff_idx  out  8  natural coefficient index, 0..255.
- coeff_valid  out  1  coeff_out and coeff_idx are valid.
- coeff_ready  in  1  consumer accepts the coefficient when coeff_valid && coeff_ready.
- busy  out  1  high from the cycle after active is accepted until finish.
- finish  out  1  one-cycle pulse after the last coefficient handshake.
- range_err  out  1  sticky out-of-range flag; see Configuration.

## Operation

- FSM states: IDLE, RUN, COMPLETE. IDLE -> RUN on active. RUN -> COMPLETE on the handshake of coefficient 256. COMPLETE -> IDLE unconditionally. active is ignored outside IDLE.
- Reset values: ren=0, raddr=0, coeff_valid=0, coeff_out=0, coeff_idx=0, busy=0, finish=0, range_err=0. All counters and buffers are cleared.
- Word w (0..31) has base b=2w. Its lanes are din[12k +: 12], k=0..7, and map to natural indices b, b+1, b+128, b+129, b+64, b+65, b+192, b+193.
- Output order: word 0 lanes 0..7, then word 1, and so on. Coefficients are not reordered into natural order; coeff_idx carries the position.
- 2-entry word buffer (current, prefetch) plus a 3-bit lane counter.
- A read is issued when words_issued < 32 and (buffered words + reads in flight) < 2. The condition is evaluated on registered state.
- Returning data fills current if current is empty, otherwise prefetch.
- On the handshake of lane 7, prefetch moves to current. If data returns in the same cycle, it lands in the freed slot.
- Coefficients are passed through unmodified. No modular arithmetic.
- When coeff_valid=1 and coeff_ready=0, coeff_out and coeff_idx hold stable until the handshake.
- A synchronous rst mid-operation aborts immediately: back to IDLE with reset values. No finish pulse.

## Timing

- active in IDLE at cycle T. Cycle T+1: ren=1, raddr=offset. Cycle T+2: ren=1, raddr=offset+1. First coeff_valid at T+3.
- With coeff_ready held high: 256 coefficients on consecutive cycles T+3..T+258, with no bubbles. finish=1 at T+259. IDLE at T+260, and a new active is accepted there.
- Backpressure stalls only reads. At most 2 words are buffered or in flight. No data is dropped.
- The raddr offset wraps mod 512. Example: offset 500 reads 500..511, then 0..19.

## Configuration

- COEFF_RANGE_CHECK_EN, defined:
  - range_err is set on any handshake with coeff_out >= 3329.
  - It stays set until the next accepted active, which clears it.
- COEFF_RANGE_CHECK_EN, undefined: range_err is tied to 0 and the comparator is absent.
- The data path and timing are identical in both builds.

## Structure

- Shared package holds:
  - KYBER_Q=3329.
  - N_COEFF=256, WORDS_PER_POLY=32, COEFF_W=12.
  - The lane-to-index offset table {0,1,128,129,64,65,192,193}.
  - The FSM state encoding.
- One sub-module, poly_word_fifo2: 2-entry 96-bit word buffer with occupancy count, push/pop, and same-cycle push+pop. The reader FSM, address generator and lane serializer stay in the top module.

## Test plan

- RAM model with word w lane k = 12'(w*8+k), offset 0, ready always high, active at T → 256 coefficients T+3..T+258. Word 0 gives idx 0,1,128,129,64,65,192,193 with values 0..7. Word 31 gives idx 62,63,190,191,126,127,254,255. finish at T+259.
- Random ready (50%) → all 256 (idx, value) pairs correct and each delivered exactly once. Output stable while stalled. ren never leaves more than 2 words buffered or in flight.
- Offset 500 → raddr sequence 500..511, 0..19. Data correct.
- rst asserted at coefficient 100 → next cycle all outputs at reset values, no finish. A new active then produces a full correct stream.
- active pulsed again during RUN → ignored, stream unchanged. Back-to-back active at T+260 → second stream starts at T+263.
- COEFF_RANGE_CHECK_EN defined, one lane = 3329 → range_err rises after that handshake, holds through finish, and clears on the next active. With the macro undefined, range_err stays 0.

Source files
------------

// File: rtl/poly_ram_reader_pkg.sv
// ----------------------------------------------------------------------------
// poly_ram_reader_pkg
// Shared constants and types for the polynomial RAM reader.
//   KYBER_Q         : Kyber modulus; used by the optional range checker.
//   N_COEFF         : coefficients per polynomial.
//   WORDS_PER_POLY  : 96-bit RAM words per polynomial.
//   COEFF_W         : coefficient width.
//   state_e         : reader FSM encoding (also exported for debug).
//   lane_offset()   : lane-to-natural-index offset table.
// ----------------------------------------------------------------------------
package poly_ram_reader_pkg;

    localparam int KYBER_Q        = 3329;
    localparam int N_COEFF        = 256;
    localparam int WORDS_PER_POLY = 32;
    localparam int COEFF_W        = 12;
    localparam int LANES          = N_COEFF / WORDS_PER_POLY;
    localparam int WORD_W         = LANES * COEFF_W;
    localparam int ADDR_W         = 9;
    localparam int IDX_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_COMPLETE = 2'd2
    } state_e;

    // The generator packs pairs from the four quarter-rings of the polynomial
    // into one word: lane k of word w holds natural index 2w + lane_offset(k).
    function automatic logic [IDX_W-1:0] lane_offset(input logic [2:0] lane);
        logic [IDX_W-1:0] off;
        case (lane)
            3'd0:    off = 8'd0;
            3'd1:    off = 8'd1;
            3'd2:    off = 8'd128;
            3'd3:    off = 8'd129;
            3'd4:    off = 8'd64;
            3'd5:    off = 8'd65;
            3'd6:    off = 8'd192;
            default: off = 8'd193;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/poly_ram_reader_if.sv
// ----------------------------------------------------------------------------
// poly_ram_reader_if
// Bundles the RAM read port and the coefficient stream of the reader.
//   RAM side   : ren, raddr (reader -> RAM), din (RAM -> reader).
//   Stream side: coeff_out, coeff_idx, coeff_valid (reader -> consumer),
//                coeff_ready (consumer -> reader).
// Handshake: a coefficient transfers on a rising clock edge where
// coeff_valid && coeff_ready; while coeff_valid is high and coeff_ready low,
// coeff_out/coeff_idx hold stable and coeff_valid stays high.
// modport master = reader, modport slave = RAM model / consumer.
// ----------------------------------------------------------------------------
interface poly_ram_reader_if;
    import poly_ram_reader_pkg::*;

    logic                 ren;
    logic [ADDR_W-1:0]    raddr;
    logic [WORD_W-1:0]    din;
    logic [COEFF_W-1:0]   coeff_out;
    logic [IDX_W-1:0]     coeff_idx;
    logic                 coeff_valid;
    logic                 coeff_ready;

    modport master (
        output ren, raddr, coeff_out, coeff_idx, coeff_valid,
        input  din, coeff_ready
    );

    modport slave (
        input  ren, raddr, coeff_out, coeff_idx, coeff_valid,
        output din, coeff_ready
    );

endinterface

// File: rtl/poly_word_fifo2.sv
// ----------------------------------------------------------------------------
// poly_word_fifo2
// Two-entry word buffer (current + prefetch) with occupancy count.
//   clk, rst     : clock, synchronous active-high reset (clears contents).
//   push_i       : write push_data_i into the first free slot.
//   push_data_i  : 96-bit RAM word.
//   pop_i        : drop the current word; prefetch moves to current.
//   head_o       : current word.
//   count_o      : occupancy 0..2.
// Push and pop in the same cycle are allowed; the pushed word lands in the
// slot freed by the pop.
// ----------------------------------------------------------------------------
module poly_word_fifo2
    import poly_ram_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [WORD_W-1:0] cur_q, cur_d;
    logic [WORD_W-1:0] pre_q, pre_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        cur_d   = cur_q;
        pre_d   = pre_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        // A full buffer only takes a new word when a slot frees this cycle.
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        case ({do_push, do_pop})
            2'b01: begin
                cur_d   = pre_q;
                pre_d   = '0;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) cur_d = push_data_i;
                else                 pre_d = push_data_i;
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    cur_d = push_data_i;
                end else begin
                    cur_d = pre_q;
                    pre_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q   <= '0;
            pre_q   <= '0;
            count_q <= '0;
        end else begin
            cur_q   <= cur_d;
            pre_q   <= pre_d;
            count_q <= count_d;
        end
    end

    assign head_o  = cur_q;
    assign count_o = count_q;

endmodule

// File: rtl/poly_ram_reader.sv
// ----------------------------------------------------------------------------
// poly_ram_reader
// Reads one Kyber polynomial (32 x 96-bit words) from the polynomial RAM and
// streams its 256 12-bit coefficients in storage order, each tagged with its
// natural index.
//   clk, rst            : clock, synchronous active-high reset.
//   active              : start pulse, sampled only in IDLE.
//   ram_r_start_offset  : base RAM address, captured with active.
//   bus (master)        : RAM read port + coefficient valid/ready stream.
//   busy                : high from the cycle after start until finish.
//   finish              : one-cycle pulse after the last coefficient.
//   range_err           : sticky coeff >= q flag (optional checker).
//   dbg_state_o         : FSM state.
// Parameter RAM_RD_LAT : RAM read latency; only 1 is supported.
// Optional feature macro: COEFF_RANGE_CHECK_EN enables range_err.
// ----------------------------------------------------------------------------
module poly_ram_reader
    import poly_ram_reader_pkg::*;
#(
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic [ADDR_W-1:0] ram_r_start_offset,
    poly_ram_reader_if.master bus,
    output logic              busy,
    output logic              finish,
    output logic              range_err,
    output state_e            dbg_state_o
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     offset_q;
    logic [5:0]            issued_q;
    logic [4:0]            word_cnt_q;
    logic [2:0]            lane_q;
    logic [RAM_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

    logic                  start;
    logic                  hs;
    logic                  last_lane;
    logic                  last_coeff;
    logic [1:0]            fifo_count;
    logic [WORD_W-1:0]     fifo_head;
    logic [2:0]            outstanding;

    assign start      = (state_q == ST_IDLE) && active;
    assign hs         = bus.coeff_valid && bus.coeff_ready;
    assign last_lane  = (lane_q == 3'd7);
    assign last_coeff = hs && last_lane && (word_cnt_q == 5'(WORDS_PER_POLY - 1));

    // Read-request shift register: the oldest stage marks RAM data valid.
    assign rd_pipe_d   = RAM_RD_LAT'({rd_pipe_q, bus.ren});
    assign outstanding = 3'(fifo_count) + 3'($countones(rd_pipe_q));

    poly_word_fifo2 u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_pipe_q[RAM_RD_LAT-1]),
        .push_data_i (bus.din),
        .pop_i       (hs && last_lane),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (active)     state_d = ST_RUN;
            ST_RUN:      if (last_coeff) state_d = ST_COMPLETE;
            ST_COMPLETE:                 state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Reads are decided on registered state only: a word popped this cycle
    // still counts, so the refill read is issued one cycle later.
    always_comb begin
        bus.ren         = (state_q == ST_RUN) && (issued_q < 6'(WORDS_PER_POLY))
                          && (outstanding < 3'd2);
        bus.coeff_valid = (state_q == ST_RUN) && (fifo_count != 2'd0);
        busy            = (state_q != ST_IDLE);
        finish          = (state_q == ST_COMPLETE);
    end

    assign dbg_state_o = state_q;
    assign bus.raddr   = offset_q + ADDR_W'(issued_q);

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q   <= '0;
            issued_q   <= '0;
            word_cnt_q <= '0;
            lane_q     <= '0;
            rd_pipe_q  <= '0;
        end else begin
            rd_pipe_q <= rd_pipe_d;
            if (start) begin
                offset_q   <= ram_r_start_offset;
                issued_q   <= '0;
                word_cnt_q <= '0;
                lane_q     <= '0;
            end else begin
                if (bus.ren) issued_q <= issued_q + 6'd1;
                if (hs) begin
                    lane_q <= lane_q + 3'd1;
                    if (last_lane) word_cnt_q <= word_cnt_q + 5'd1;
                end
            end
        end
    end

    // ---------------- lane serializer ----------------
    // Output is a pure function of the held word and lane counter, so it is
    // stable for as long as the consumer stalls.
    always_comb begin
        bus.coeff_out = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_q == 3'(k)) bus.coeff_out = fifo_head[k*COEFF_W +: COEFF_W];
        end
    end

    assign bus.coeff_idx = IDX_W'({word_cnt_q, 1'b0}) + lane_offset(lane_q);

    // ---------------- optional range checker ----------------
`ifdef COEFF_RANGE_CHECK_EN
    logic range_err_q;

    always_ff @(posedge clk) begin
        if (rst)        range_err_q <= 1'b0;
        else if (start) range_err_q <= 1'b0;
        else if (hs && (bus.coeff_out >= COEFF_W'(KYBER_Q))) range_err_q <= 1'b1;
    end

    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;
`endif

endmodule
